// File: rtl/mux8_pkg.sv
// Shared constants and state encoding for the 8-channel TDM mux family.
package mux8_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } tdm_state_t;
endpackage

// File: rtl/mux8to1_comb.sv
// Pure combinational 8:1 select, Y = D[S].
module mux8to1_comb
    import mux8_pkg::*;
(
    input  logic [NUM_CH-1:0] D,
    input  logic [SEL_W-1:0]  S,
    output logic              Y
);
    assign Y = D[S];
endmodule

// File: rtl/mux8to1_tdm_tx.sv
// TDM transmitter: serializes one 8-bit channel word per frame onto Y, with S as channel index.
// Optional even-parity 9th slot when MUX8TO1_TDM_PARITY_EN is defined.
module mux8to1_tdm_tx
    import mux8_pkg::*;
#(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] Din,
    input  logic              Din_valid,
    output logic              Din_ready,
    output logic              Y,
    output logic [SEL_W-1:0]  S,
    output logic              Y_valid,
    output logic              frame_start
);
`ifdef MUX8TO1_TDM_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    tdm_state_t       state_q, state_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic [NUM_CH-1:0] cap_q;
    logic             accept;
    logic             last_slot;
    logic             mux_y;
    logic             par_y;

    mux8to1_comb u_sel (
        .D (cap_q),
        .S (slot_q),
        .Y (mux_y)
    );

    assign par_y = ^cap_q;

    // The frame's final slot reopens the input so frames can run back to back.
    assign last_slot = (state_q == PARITY) ||
                       ((state_q == SEND) && (slot_q == 3'd7) && !PAR_EN);
    assign Din_ready = (state_q == IDLE) || last_slot;
    assign accept    = Din_valid && Din_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            slot_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (accept) cap_q <= Din;
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                slot_d = '0;
                if (accept) state_d = SEND;
            end
            SEND: begin
                if (slot_q == 3'd7 && PAR_EN) begin
                    // slot stays at 7 so S holds through the parity slot
                    state_d = PARITY;
                end else begin
                    slot_d = slot_q + 3'd1;
                    if (slot_q == 3'd7 && !accept) state_d = IDLE;
                end
            end
            PARITY: begin
                slot_d  = '0;
                state_d = accept ? SEND : IDLE;
            end
            default: begin
                state_d = IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_comb begin
        Y           = IDLE_VAL;
        S           = '0;
        Y_valid     = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            SEND: begin
                Y           = mux_y;
                S           = slot_q;
                Y_valid     = 1'b1;
                frame_start = (slot_q == 3'd0);
            end
            PARITY: begin
                Y       = par_y;
                S       = slot_q;
                Y_valid = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mux8to1_tdm_tx.sv
// Directed self-checking bench for mux8to1_tdm_tx; also covers the parity slot
// when built with MUX8TO1_TDM_PARITY_EN.
module tb_mux8to1_tdm_tx;
    import mux8_pkg::*;

`ifdef MUX8TO1_TDM_PARITY_EN
    localparam int FLEN = 9;
`else
    localparam int FLEN = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Din = 8'h00;
    logic       Din_valid = 1'b0;
    logic       Din_ready;
    logic       Y;
    logic [2:0] S;
    logic       Y_valid;
    logic       frame_start;

    int tests = 0;
    int fails = 0;

    mux8to1_tdm_tx #(.IDLE_VAL(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Din        (Din),
        .Din_valid  (Din_valid),
        .Din_ready  (Din_ready),
        .Y          (Y),
        .S          (S),
        .Y_valid    (Y_valid),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        Din_valid = 1'b0;
        tick(); tick();
        tests++;
        if ({Y_valid, Din_ready, Y, S, frame_start} !== 7'b0100000) begin
            fails++;
            $display("FAIL reset_hold: got vld=%b rdy=%b y=%b s=%0d fs=%b, want 0 1 0 0 0",
                     Y_valid, Din_ready, Y, S, frame_start);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({Y_valid, Din_ready, Y, S, frame_start} !== 7'b0100000) begin
                fails++;
                $display("FAIL idle_%0d: got vld=%b rdy=%b y=%b s=%0d fs=%b, want 0 1 0 0 0",
                         i, Y_valid, Din_ready, Y, S, frame_start);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] yexp;
        logic       ey;
        yexp = 8'b1010_0110;          // bits 0..7 on Y: 0,1,1,0,0,1,0,1
        Din = 8'b1010_0110;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        for (int k = 0; k < FLEN; k++) begin
            ey = (k < 8) ? yexp[k] : 1'b0;  // parity of 0xA6 (four ones) is 0
            tests++;
            if (Y !== ey || S !== ((k < 8) ? 3'(k) : 3'd7) || Y_valid !== 1'b1 ||
                frame_start !== (k == 0) || Din_ready !== (k == FLEN - 1)) begin
                fails++;
                $display("FAIL single_slot%0d: got y=%b s=%0d vld=%b fs=%b rdy=%b, want y=%b s=%0d vld=1 fs=%b rdy=%b",
                         k, Y, S, Y_valid, frame_start, Din_ready, ey,
                         (k < 8) ? k : 7, k == 0, k == FLEN - 1);
            end
            tick();
        end
        tests++;
        if (Y_valid !== 1'b0 || Din_ready !== 1'b1 || S !== 3'd0 || Y !== 1'b0) begin
            fails++;
            $display("FAIL single_idle: got vld=%b rdy=%b s=%0d y=%b, want 0 1 0 0",
                     Y_valid, Din_ready, S, Y);
        end
    endtask

    task automatic test_back_to_back();
        int slot;
        logic ey;
        Din = 8'hFF;
        Din_valid = 1'b1;
        tick();
        for (int k = 0; k < 2 * FLEN; k++) begin
            slot = k % FLEN;
            // 0xFF and 0x00 both have even parity 0
            ey = (k < FLEN && slot < 8) ? 1'b1 : 1'b0;
            tests++;
            if (Y !== ey || S !== ((slot < 8) ? 3'(slot) : 3'd7) || Y_valid !== 1'b1 ||
                frame_start !== (slot == 0)) begin
                fails++;
                $display("FAIL b2b_k%0d: got y=%b s=%0d vld=%b fs=%b, want y=%b s=%0d vld=1 fs=%b",
                         k, Y, S, Y_valid, frame_start, ey, (slot < 8) ? slot : 7, slot == 0);
            end
            if (k == FLEN - 1) Din = 8'h00;
            if (k == 2 * FLEN - 1) Din_valid = 1'b0;
            tick();
        end
        tests++;
        if (Y_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got vld=%b, want 0", Y_valid);
        end
    endtask

    task automatic test_stall_hold();
        logic [7:0] a, b;
        logic       ey;
        a = 8'h3C;                    // bits 0..7: 0,0,1,1,1,1,0,0, parity 0
        b = 8'h81;                    // bits 0..7: 1,0,0,0,0,0,0,1
        Din = a;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        tick(); tick(); tick();
        Din = b;
        Din_valid = 1'b1;
        for (int k = 3; k < FLEN; k++) begin
            ey = (k < 8) ? a[k] : 1'b0;
            tests++;
            if (Din_ready !== (k == FLEN - 1) || Y !== ey ||
                S !== ((k < 8) ? 3'(k) : 3'd7)) begin
                fails++;
                $display("FAIL stall_slot%0d: got rdy=%b y=%b s=%0d, want rdy=%b y=%b s=%0d",
                         k, Din_ready, Y, S, k == FLEN - 1, ey, (k < 8) ? k : 7);
            end
            if (k == 4) Din = 8'hAA;
            if (k == 6) Din = b;
            tick();
        end
        Din_valid = 1'b0;
        Din = 8'h00;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (Y !== b[k] || S !== 3'(k) || Y_valid !== 1'b1 || frame_start !== (k == 0)) begin
                fails++;
                $display("FAIL stall_next%0d: got y=%b s=%0d vld=%b fs=%b, want y=%b s=%0d vld=1 fs=%b",
                         k, Y, S, Y_valid, frame_start, b[k], k, k == 0);
            end
            tick();
        end
        for (int k = 8; k < FLEN; k++) tick();
        tests++;
        if (Y_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_end: got vld=%b, want 0", Y_valid);
        end
    endtask

    task automatic test_midframe_reset();
        logic [7:0] c;
        c = 8'h0F;                    // bits 0..7: 1,1,1,1,0,0,0,0
        Din = 8'hF0;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        tick(); tick(); tick(); tick();
        tests++;
        if (S !== 3'd4 || Y !== 1'b1) begin
            fails++;
            $display("FAIL mr_slot4: got s=%0d y=%b, want s=4 y=1", S, Y);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({Y_valid, Din_ready, Y, S, frame_start} !== 7'b0100000) begin
            fails++;
            $display("FAIL mr_async: got vld=%b rdy=%b y=%b s=%0d fs=%b, want 0 1 0 0 0",
                     Y_valid, Din_ready, Y, S, frame_start);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (Y_valid !== 1'b0) begin
            fails++;
            $display("FAIL mr_noresume: got vld=%b, want 0", Y_valid);
        end
        Din = c;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (Y !== c[k] || S !== 3'(k) || Y_valid !== 1'b1 || frame_start !== (k == 0)) begin
                fails++;
                $display("FAIL mr_frame%0d: got y=%b s=%0d vld=%b fs=%b, want y=%b s=%0d vld=1 fs=%b",
                         k, Y, S, Y_valid, frame_start, c[k], k, k == 0);
            end
            tick();
        end
        for (int k = 8; k < FLEN; k++) tick();
    endtask

`ifdef MUX8TO1_TDM_PARITY_EN
    task automatic test_parity();
        Din = 8'b0000_0111;
        Din_valid = 1'b1;
        tick();
        Din_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        tests++;
        if (S !== 3'd7 || Din_ready !== 1'b0) begin
            fails++;
            $display("FAIL par_slot7: got s=%0d rdy=%b, want s=7 rdy=0", S, Din_ready);
        end
        Din = 8'h01;
        Din_valid = 1'b1;
        tick();
        tests++;
        if (Y !== 1'b1 || S !== 3'd7 || frame_start !== 1'b0 || Y_valid !== 1'b1 ||
            Din_ready !== 1'b1) begin
            fails++;
            $display("FAIL par_slot: got y=%b s=%0d fs=%b vld=%b rdy=%b, want 1 7 0 1 1",
                     Y, S, frame_start, Y_valid, Din_ready);
        end
        tick();
        Din_valid = 1'b0;
        tests++;
        if (S !== 3'd0 || frame_start !== 1'b1 || Y !== 1'b1 || Y_valid !== 1'b1) begin
            fails++;
            $display("FAIL par_next: got s=%0d fs=%b y=%b vld=%b, want 0 1 1 1",
                     S, frame_start, Y, Y_valid);
        end
        for (int k = 0; k < 9; k++) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall_hold();
        test_midframe_reset();
`ifdef MUX8TO1_TDM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux8to1_tdm_tx.md
# mux8to1_tdm_tx

Time-division 8-to-1 multiplexer that serializes one 8-channel sample word onto a single output line, one channel per clock, reporting the active channel index on `S`. It is the transmit-side counterpart of the 1-to-8 demultiplexer: its `Y`/`S` stream drives a demux's `Din`/`S` so that each bit returns to its own channel. It sits between a parallel sample source and the shared serial line.

## Interface
- `IDLE_VAL`, default 1'b0: level driven on `Y` while no frame is in progress.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous active-low reset.
- `Din` input 8: channel word; bit k is channel k.
- `Din_valid` input 1: source has a word on `Din`.
- `Din_ready` output 1: block accepts `Din` this cycle.
- `Y` output 1: serialized channel bit.
- `S` output 3: channel index currently on `Y`.
- `Y_valid` output 1: `Y`/`S` carry a channel (or parity) slot.
- `frame_start` output 1: high during the slot with `S`=0.

## Operation
- Handshake: a word is accepted on a rising edge where `Din_valid && Din_ready`. `Din` is captured into an internal 8-bit register. The source must hold `Din` stable while `Din_valid` is high and `Din_ready` is low.
- States:
  - IDLE: `Din_ready`=1, `Y_valid`=0, `Y`=`IDLE_VAL`, `S`=0. On accept, go to SEND with slot counter=0.
  - SEND: `Y` = captured[slot], `S` = slot, `Y_valid`=1. The counter increments each cycle.
  - From slot 7: go to PARITY if enabled (see Configuration), otherwise go to IDLE.
  - PARITY (only if `PARITY_EN` is defined): one extra slot, then IDLE.
- Last-slot acceptance: `Din_ready` is also high during the final slot of a frame (slot 7, or PARITY when enabled).
  - Accepting in that slot restarts SEND at slot 0 on the next cycle.
  - Frames are back-to-back with no idle gap. The capture register is loaded at the same edge.
- `Din_ready` is combinational from state and counter only. It never depends on `Din_valid`.
- `Din_valid` deasserting mid-frame has no effect. A captured frame always completes.
- Slot counter is 3 bits and wraps naturally from 7 to 0. No wider arithmetic.

## Timing
- Reset values (async assert, sync deassert expected from the system): state=IDLE, counter=0, capture register=0.
  - Outputs after reset: `Y`=`IDLE_VAL`, `S`=0, `Y_valid`=0, `frame_start`=0, `Din_ready`=1.
- Latency: word accepted at edge N, then channel 0 is on `Y` during cycle N+1 and channel 7 during cycle N+8.
- All outputs except `Din_ready` are registered or decoded from registered state. There is no combinational path from `Din`/`Din_valid` to `Y`/`S`.
- Sustained throughput: one word per 8 cycles, or per 9 cycles with `PARITY_EN`.
- Reset mid-frame: abort immediately. Outputs return to reset values, the partial frame is dropped, and there is no resume.

## Configuration
- `MUX8TO1_TDM_PARITY_EN`:
  - When defined: a 9th slot follows slot 7, with `Y` = even parity (XOR of the 8 captured bits), `S`=7 held, `Y_valid`=1, `frame_start`=0. `Din_ready` is high in the parity slot and low in slot 7.
  - When undefined: frame is 8 slots and `Din_ready` is high in slot 7.

## Structure
- Shared package `mux8_pkg`:
  - `NUM_CH`=8.
  - `SEL_W`=3.
  - State enum `tdm_state_t` {IDLE, SEND, PARITY}.
- Sub-module `mux8to1_comb`: pure combinational 8:1 select, `Y = D[S]`. It is instantiated once on the capture register and the slot counter.

## Test plan
- Reset, then idle: hold `rst_n`=0 for 2 cycles, release, keep `Din_valid`=0 for 5 cycles -> `Y`=`IDLE_VAL`, `Y_valid`=0, `Din_ready`=1, `S`=0 throughout.
- Single frame: `Din`=8'b1010_0110 accepted at edge N -> cycles N+1..N+8 show `S`=0..7 and `Y`=0,1,1,0,0,1,0,1; `frame_start` only at N+1; IDLE at N+9.
- Back-to-back frames: `Din_valid` held high with 8'hFF then 8'h00 -> second frame's `S`=0 follows first frame's `S`=7 with no gap; `Y` is eight 1s then eight 0s.
- Stall and hold: assert `Din_valid` with 8'h81 at slot 3 of a running frame -> `Din_ready` low until the last slot; 8'h81 starts immediately after; `Din` changes while not ready are ignored.
- Mid-frame reset: pull `rst_n` low during slot 4 of 8'hF0 -> outputs at reset values asynchronously; after release, the next accepted 8'h0F transmits cleanly from `S`=0.
- With `MUX8TO1_TDM_PARITY_EN`: `Din`=8'b0000_0111 -> 9th slot `Y`=1, `S`=7, `frame_start`=0; next word accepted in the parity slot starts at `S`=0 the following cycle.
